// File: rtl/instr_encoder.sv
// RV32I field-bundle encoder with an output buffer; ENC_RANGE_CHECK_EN adds immediate range checking.
// Latency: an accepted bundle appears at the head one cycle later when the buffer is empty, otherwise in FIFO order.
// Backpressure: ready_o drops when the buffer is full and depends only on registered occupancy, never on ready_i.
module instr_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [6:0]                    opcode_i,
    input  logic [2:0]                    funct3_i,
    input  logic [6:0]                    funct7_i,
    input  logic [4:0]                    rd_addr_i,
    input  logic [4:0]                    rs1_addr_i,
    input  logic [4:0]                    rs2_addr_i,
    input  logic [31:0]                   imm_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [31:0]                   instr_o,
    output logic                          illegal_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic        illegal;
        logic [31:0] instr;
    } entry_t;

    entry_t          mem [FIFO_DEPTH];
    entry_t          enc;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    logic [31:0] imm;
    logic        rng_is, rng_b, rng_j, rng_u;
    assign imm = imm_i;

`ifdef ENC_RANGE_CHECK_EN
    logic signed [31:0] imm_s;
    assign imm_s  = $signed(imm_i);
    assign rng_is = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
    assign rng_b  = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm_i[0];
    assign rng_j  = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm_i[0];
    assign rng_u  = (imm_i[11:0] != 12'd0);
`else
    assign rng_is = 1'b0;
    assign rng_b  = 1'b0;
    assign rng_j  = 1'b0;
    assign rng_u  = 1'b0;
`endif

    always_comb begin
        enc.illegal = 1'b0;
        enc.instr   = 32'h0000_0013;
        case (opcode_i)
            7'b0110011: enc.instr = {funct7_i, rs2_addr_i, rs1_addr_i, funct3_i, rd_addr_i, opcode_i};
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                enc.instr   = {imm[11:0], rs1_addr_i, funct3_i, rd_addr_i, opcode_i};
                enc.illegal = rng_is;
            end
            7'b0100011: begin
                enc.instr   = {imm[11:5], rs2_addr_i, rs1_addr_i, funct3_i, imm[4:0], opcode_i};
                enc.illegal = rng_is;
            end
            7'b1100011: begin
                enc.instr   = {imm[12], imm[10:5], rs2_addr_i, rs1_addr_i, funct3_i,
                               imm[4:1], imm[11], opcode_i};
                enc.illegal = rng_b;
            end
            7'b0110111, 7'b0010111: begin
                enc.instr   = {imm[31:12], rd_addr_i, opcode_i};
                enc.illegal = rng_u;
            end
            7'b1101111: begin
                enc.instr   = {imm[20], imm[10:1], imm[11], imm[19:12], rd_addr_i, opcode_i};
                enc.illegal = rng_j;
            end
            default: enc.illegal = 1'b1;
        endcase
    end

    assign ready_o = (count < CW'(FIFO_DEPTH));
    assign valid_o = (count != '0);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;
    assign count_o = count;

    // Gating on valid_o keeps the head outputs at zero during and after reset/flush.
    assign instr_o   = valid_o ? mem[rd_ptr].instr   : 32'd0;
    assign illegal_o = valid_o ? mem[rd_ptr].illegal : 1'b0;

    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem[wr_ptr] <= enc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder; a scoreboard queue holds the expected head entries in order.
module tb_instr_encoder;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [4:0]  rd_addr_i, rs1_addr_i, rs2_addr_i;
    logic [31:0] imm_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic        illegal_o;
    logic [2:0]  count_o;

    int tests = 0;
    int errs  = 0;
    logic [32:0] sb[$];
    logic [32:0] exp_cur;
    logic [32:0] got;
    logic        ill_800;

    instr_encoder #(.FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i), .rd_addr_i(rd_addr_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .imm_i(imm_i), .valid_o(valid_o),
        .ready_i(ready_i), .instr_o(instr_o), .illegal_o(illegal_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        tests++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [31:0] ex_instr, input logic ex_ill);
        opcode_i = op; funct3_i = f3; funct7_i = f7;
        rd_addr_i = rd; rs1_addr_i = rs1; rs2_addr_i = rs2; imm_i = imm;
        exp_cur = {ex_ill, ex_instr};
        valid_i = 1'b1;
        step();
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        ready_i = 1'b1;
        valid_i = 1'b0;
        while ((sb.size() != 0 || valid_o) && budget < 50) begin
            step();
            budget++;
        end
        chk("drain_done", {32'd0, budget < 50}, 33'd1);
    endtask

    // Scoreboard: record accepts and compare pops, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (rst_ni && !flush_i && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {illegal_o, instr_o}, 33'h1_dead_beef);
            end else begin
                got = sb.pop_front();
                chk("head_entry", {illegal_o, instr_o}, got);
            end
        end
        if (rst_ni && !flush_i && valid_i && ready_o) sb.push_back(exp_cur);
    end

    initial begin
`ifdef ENC_RANGE_CHECK_EN
        ill_800 = 1'b1;
`else
        ill_800 = 1'b0;
`endif
        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        opcode_i = '0; funct3_i = '0; funct7_i = '0;
        rd_addr_i = '0; rs1_addr_i = '0; rs2_addr_i = '0; imm_i = '0; exp_cur = '0;
        #2;
        chk("rst_count", {30'd0, count_o}, 33'd0);
        chk("rst_valid", {32'd0, valid_o}, 33'd0);
        chk("rst_ready", {32'd0, ready_o}, 33'd1);
        chk("rst_head",  {illegal_o, instr_o}, 33'd0);
        step(); step();
        rst_ni = 1'b1;
        step();

        // Single ADDI: visible the cycle after acceptance.
        ready_i = 1'b1;
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd4, 32'h0040_8093, 1'b0);
        chk("addi_latency_valid", {32'd0, valid_o}, 33'd1);
        valid_i = 1'b0;
        step();

        // Back-to-back mix of formats; count holds at 1 while accepting and popping together.
        send(7'h23, 3'd2, 7'd0,  5'd0, 5'd0, 5'd2, 32'd4,          32'h0020_2223, 1'b0);
        send(7'h63, 3'd0, 7'd0,  5'd0, 5'd0, 5'd0, 32'd8,          32'h0000_0463, 1'b0);
        chk("stream_count", {30'd0, count_o}, 33'd1);
        send(7'h37, 3'd0, 7'd0,  5'd2, 5'd0, 5'd0, 32'h0000_1000,  32'h0000_1137, 1'b0);
        send(7'h6F, 3'd0, 7'd0,  5'd0, 5'd0, 5'd0, 32'd0,          32'h0000_006F, 1'b0);
        send(7'h6F, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC,  32'hFFDF_F0EF, 1'b0);
        send(7'h33, 3'd0, 7'd0,  5'd3, 5'd1, 5'd2, 32'hFFFF_FFFF,  32'h0020_81B3, 1'b0);
        send(7'h33, 3'd0, 7'h20, 5'd5, 5'd6, 5'd7, 32'd0,          32'h4073_02B3, 1'b0);
        send(7'h17, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'hFFFF_F000,  32'hFFFF_F097, 1'b0);
        send(7'h13, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF,  32'hFFF0_0093, 1'b0);
        send(7'h00, 3'd0, 7'd0,  5'd1, 5'd2, 5'd3, 32'd4,          32'h0000_0013, 1'b1);
        send(7'h13, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'h0000_0800,  32'h8000_0093, ill_800);
        chk("stream_count_end", {30'd0, count_o}, 33'd1);
        drain();

        // Fill to full with the consumer stalled; the fifth bundle is dropped.
        ready_i = 1'b0;
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
        send(7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113, 1'b0);
        chk("stall_head_stable", {illegal_o, instr_o}, 33'h0_0010_0093);
        send(7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3, 32'h0030_0193, 1'b0);
        send(7'h13, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd4, 32'h0040_0213, 1'b0);
        chk("full_count", {30'd0, count_o}, 33'd4);
        chk("full_ready", {32'd0, ready_o}, 33'd0);
        send(7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd5, 32'h0050_0293, 1'b0);
        chk("full_drop_count", {30'd0, count_o}, 33'd4);
        chk("full_head_stable", {illegal_o, instr_o}, 33'h0_0010_0093);
        chk("sb_depth", {1'b0, 32'(sb.size())}, 33'd4);
        drain();

        // Flush a full buffer while a bundle is offered.
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++)
            send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4, 32'h0040_0093, 1'b0);
        flush_i = 1'b1;
        send(7'h13, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'd9, 32'h0090_0493, 1'b0);
        flush_i = 1'b0;
        valid_i = 1'b0;
        sb.delete();
        chk("flush_count", {30'd0, count_o}, 33'd0);
        chk("flush_valid", {32'd0, valid_o}, 33'd0);
        chk("flush_ready", {32'd0, ready_o}, 33'd1);
        step();
        chk("flush_stays_empty", {30'd0, count_o}, 33'd0);

        // Asynchronous reset with three entries buffered.
        for (int i = 0; i < 3; i++)
            send(7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd7, 32'h0070_0113, 1'b0);
        valid_i = 1'b0;
        chk("pre_reset_count", {30'd0, count_o}, 33'd3);
        #2 rst_ni = 1'b0;
        #1;
        sb.delete();
        chk("arst_count", {30'd0, count_o}, 33'd0);
        chk("arst_valid", {32'd0, valid_o}, 33'd0);
        chk("arst_head",  {illegal_o, instr_o}, 33'd0);
        step();
        rst_ni = 1'b1;
        step();
        ready_i = 1'b1;
        send(7'h37, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'h0000_1000, 32'h0000_1137, 1'b0);
        chk("post_reset_valid", {32'd0, valid_o}, 33'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
